// File: rtl/alu_cmd_issuer_if.sv
// Host command, ALU pin and response bundle for alu_cmd_issuer.
// master = issuer side, slave = host/ALU environment side.
interface alu_cmd_issuer_if #(parameter int TAG_W = 4);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [4:0]       cmd_a;
    logic [4:0]       cmd_b;
    logic [1:0]       cmd_mode;
    logic [2:0]       cmd_aop;
    logic [1:0]       cmd_bop;
    logic [TAG_W-1:0] cmd_tag;
    logic             alu_en;
    logic [4:0]       alu_a;
    logic [4:0]       alu_b;
    logic             alu_a_en;
    logic             alu_b_en;
    logic [2:0]       alu_aop;
    logic [1:0]       alu_bop;
    logic [5:0]       alu_c;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [5:0]       rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             busy;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_aop, cmd_bop, cmd_tag,
        output cmd_ready,
        output alu_en, alu_a, alu_b, alu_a_en, alu_b_en, alu_aop, alu_bop,
        input  alu_c,
        output rsp_valid, rsp_data, rsp_tag, rsp_err,
        input  rsp_ready,
        output busy
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_aop, cmd_bop, cmd_tag,
        input  cmd_ready,
        input  alu_en, alu_a, alu_b, alu_a_en, alu_b_en, alu_aop, alu_bop,
        output alu_c,
        input  rsp_valid, rsp_data, rsp_tag, rsp_err,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Command FIFO plus single-op-in-flight FSM that drives the ALU pins,
// captures the registered ALU result and returns it with the request tag.
module alu_cmd_issuer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_cmd_issuer_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [4:0]       a;
        logic [4:0]       b;
        logic [1:0]       mode;
        logic [2:0]       aop;
        logic [1:0]       bop;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    cmd_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    state_t          state_q, state_d;
    cmd_t            op_q, op_d;
    logic [5:0]      rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic            rsp_err_q, rsp_err_d;
    logic            push, pop, drv;
    cmd_t            cmd_in, head;

    // Mode 00 is a no-op; the two single-operand codes with no real function
    // are still issued but flagged.
    function automatic logic is_err(cmd_t c);
        return (c.mode == 2'b00) ||
               (c.mode == 2'b10 && c.aop == 3'd7) ||
               (c.mode == 2'b01 && c.bop == 2'd3);
    endfunction

    assign cmd_in = '{a: bus.cmd_a, b: bus.cmd_b, mode: bus.cmd_mode,
                      aop: bus.cmd_aop, bop: bus.cmd_bop, tag: bus.cmd_tag};
    assign head   = mem_q[rd_ptr_q];
    assign push   = bus.cmd_valid && (count_q != FULL_CNT);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_err_d  = rsp_err_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: if (count_q != '0) begin
                pop       = 1'b1;
                op_d      = head;
                rsp_tag_d = head.tag;
                rsp_err_d = is_err(head);
                state_d   = ISSUE;
            end
            ISSUE: begin
                if (op_q.mode == 2'b00) begin
                    rsp_data_d = '0;
                    state_d    = RESP;
                end else begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                rsp_data_d = bus.alu_c;
                state_d    = RESP;
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Pins carry the op through ISSUE and CAPT; a no-op never touches the ALU.
    assign drv          = (state_q == ISSUE && op_q.mode != 2'b00) || state_q == CAPT;
    assign bus.alu_en   = (state_q == ISSUE) && (op_q.mode != 2'b00);
    assign bus.alu_a    = drv ? op_q.a       : '0;
    assign bus.alu_b    = drv ? op_q.b       : '0;
    assign bus.alu_a_en = drv ? op_q.mode[1] : 1'b0;
    assign bus.alu_b_en = drv ? op_q.mode[0] : 1'b0;
    assign bus.alu_aop  = drv ? op_q.aop     : '0;
    assign bus.alu_bop  = drv ? op_q.bop     : '0;

    assign bus.cmd_ready = (count_q != FULL_CNT);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != IDLE) || (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
            rsp_err_q  <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a small registered ALU stand-in.
module tb_alu_cmd_issuer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;
    int   rv_cnt = 0;

    alu_cmd_issuer_if #(.TAG_W(4)) bus ();
    alu_cmd_issuer #(.DEPTH(4), .TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // ALU stand-in: operands sign-extended to 6 bits, result registered on alu_en.
    function automatic logic [5:0] alu_f(logic [4:0] a, logic [4:0] b, logic ae, logic be,
                                         logic [2:0] aop, logic [1:0] bop);
        logic [5:0] sa, sb;
        sa = {a[4], a};
        sb = {b[4], b};
        case ({ae, be})
            2'b10: case (aop)
                3'd0: return sa + sb;
                3'd1: return sa - sb;
                3'd7: return 6'h3F;
                default: return 6'h00;
            endcase
            2'b01: return (bop == 2'd3) ? 6'h3F : sb;
            2'b11: case (bop)
                2'd0: return sa + sb;
                2'd1: return sa - sb;
                2'd2: return sa - 6'd1;
                default: return sb + 6'd2;
            endcase
            default: return 6'h00;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.alu_c <= 6'h00;
        else if (bus.alu_en) bus.alu_c <= alu_f(bus.alu_a, bus.alu_b, bus.alu_a_en,
                                                bus.alu_b_en, bus.alu_aop, bus.alu_bop);
    end

    always @(negedge clk) begin
        if (bus.alu_en === 1'b1) en_cnt++;
        if (bus.rsp_valid === 1'b1) rv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic [4:0] a, input logic [4:0] b, input logic [1:0] mode,
                           input logic [2:0] aop, input logic [1:0] bop, input logic [3:0] tag);
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_mode = mode;
        bus.cmd_aop = aop; bus.cmd_bop = bop; bus.cmd_tag = tag;
        bus.cmd_valid = 1'b1;
    endtask

    // Called at a negedge; returns at the next negedge with cmd_valid dropped.
    task automatic push(input logic [4:0] a, input logic [4:0] b, input logic [1:0] mode,
                        input logic [2:0] aop, input logic [1:0] bop, input logic [3:0] tag);
        set_cmd(a, b, mode, aop, bop, tag);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 50 && bus.rsp_valid !== 1'b1; i++) @(negedge clk);
        chk(tag, bus.rsp_valid, 1'b1);
    endtask

    task automatic take_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int e0, acc;
        logic [3:0] k;
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        set_cmd('0, '0, '0, '0, '0, '0);
        bus.cmd_valid = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_alu_en", bus.alu_en, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Mode 10 aop 0, 5+3, latency check
        e0 = en_cnt;
        push(5'd5, 5'd3, 2'b10, 3'd0, 2'd0, 4'd2);
        chk("lat_n1_en", bus.alu_en, 0);
        chk("lat_n1_busy", bus.busy, 1);
        @(negedge clk);
        chk("lat_n2_en", bus.alu_en, 1);
        chk("lat_n2_a", bus.alu_a, 5'd5);
        chk("lat_n2_aen", {bus.alu_a_en, bus.alu_b_en}, 2'b10);
        @(negedge clk);
        chk("lat_n3_en", bus.alu_en, 0);
        chk("lat_n3_b_hold", bus.alu_b, 5'd3);
        chk("lat_n3_rv", bus.rsp_valid, 0);
        @(negedge clk);
        chk("lat_n4_rv", bus.rsp_valid, 1);
        chk("add_data", bus.rsp_data, 6'd8);
        chk("add_tag", bus.rsp_tag, 4'd2);
        chk("add_err", bus.rsp_err, 0);
        chk("add_en_pulses", en_cnt - e0, 1);
        take_rsp();
        chk("idle_rv", bus.rsp_valid, 0);
        chk("idle_pins", bus.alu_a, 0);

        // Mode 01 bop 3: issued, flagged
        e0 = en_cnt;
        push(5'd1, 5'd1, 2'b01, 3'd0, 2'd3, 4'd3);
        wait_rsp("m01_to");
        chk("m01_data", bus.rsp_data, 6'h3F);
        chk("m01_err", bus.rsp_err, 1);
        chk("m01_en", en_cnt - e0, 1);
        take_rsp();

        // Mode 00: never touches the ALU
        e0 = en_cnt;
        push(5'd7, 5'd7, 2'b00, 3'd1, 2'd1, 4'd4);
        wait_rsp("m00_to");
        chk("m00_data", bus.rsp_data, 0);
        chk("m00_err", bus.rsp_err, 1);
        chk("m00_tag", bus.rsp_tag, 4'd4);
        chk("m00_en", en_cnt - e0, 0);
        take_rsp();

        // Fill: DEPTH+1 accepted with responses blocked
        acc = 0; k = 4'd0;
        for (int i = 0; i < 8; i++) begin
            set_cmd(5'(k), 5'd1, 2'b11, 3'd0, 2'd0, k);
            if (bus.cmd_ready === 1'b1) begin acc++; k++; end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        chk("fill_accepted", acc, 5);
        chk("fill_ready", bus.cmd_ready, 0);
        for (int j = 0; j < 5; j++) begin
            wait_rsp("drain_to");
            chk("drain_tag", bus.rsp_tag, j);
            chk("drain_data", bus.rsp_data, j + 1);
            take_rsp();
        end
        chk("drain_busy", bus.busy, 0);

        // Mode 11 bop 2 (A-1) and bop 3 (B+2)
        push(5'b11100, 5'd0, 2'b11, 3'd0, 2'd2, 4'd6);
        wait_rsp("m11a_to");
        chk("m11_bop2", bus.rsp_data, 6'h3B);
        chk("m11_bop2_err", bus.rsp_err, 0);
        take_rsp();
        push(5'd0, 5'd3, 2'b11, 3'd0, 2'd3, 4'd7);
        wait_rsp("m11b_to");
        chk("m11_bop3", bus.rsp_data, 6'd5);
        take_rsp();

        // Response held under backpressure
        e0 = en_cnt;
        push(5'd7, 5'b11110, 2'b10, 3'd1, 2'd0, 4'd9);
        wait_rsp("hold_to");
        for (int i = 0; i < 10; i++) begin
            chk("hold_rv", bus.rsp_valid, 1);
            chk("hold_data", bus.rsp_data, 6'd9);
            chk("hold_tag", bus.rsp_tag, 4'd9);
            @(negedge clk);
        end
        chk("hold_en", en_cnt - e0, 1);
        take_rsp();

        // Reset during CAPT with two queued
        set_cmd(5'd9, 5'd2, 2'b10, 3'd0, 2'd0, 4'd10);
        @(negedge clk);
        set_cmd(5'd1, 5'd1, 2'b10, 3'd0, 2'd0, 4'd11);
        @(negedge clk);
        set_cmd(5'd2, 5'd2, 2'b10, 3'd0, 2'd0, 4'd12);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("capt_en", bus.alu_en, 0);
        chk("capt_a_hold", bus.alu_a, 5'd9);
        rst_n = 1'b0;
        #1;
        chk("mrst_a", bus.alu_a, 0);
        chk("mrst_aen", bus.alu_a_en, 0);
        chk("mrst_rv", bus.rsp_valid, 0);
        chk("mrst_tag", bus.rsp_tag, 0);
        chk("mrst_ready", bus.cmd_ready, 1);
        chk("mrst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        e0 = en_cnt; acc = rv_cnt;
        repeat (10) @(negedge clk);
        chk("post_rst_en", en_cnt - e0, 0);
        chk("post_rst_rv", rv_cnt - acc, 0);
        chk("post_rst_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
